// File: rtl/uart_cmd_wrapper_if.sv
// uart_cmd_wrapper_if: host serial lines plus command/response handshakes
`timescale 1ns/1ps
interface uart_cmd_wrapper_if;
  logic RX;
  logic TX;
  logic [15:0] cmd;
  logic cmd_rdy;
  logic clr_cmd_rdy;
  logic [7:0] resp;
  logic send_resp;
  logic resp_sent;
  logic tx_busy;
  modport master(output RX, clr_cmd_rdy, resp, send_resp, input TX, cmd, cmd_rdy, resp_sent, tx_busy);
  modport slave(input RX, clr_cmd_rdy, resp, send_resp, output TX, cmd, cmd_rdy, resp_sent, tx_busy);
endinterface

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: 8N1 UART pairing received bytes into 16-bit commands and sending 8-bit responses
`timescale 1ns/1ps
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604
) (
  input logic clk,
  input logic rst_n,
  uart_cmd_wrapper_if.slave bus
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic {W_HI, W_LO} pr_t;
  typedef enum logic {T_IDLE, T_XMIT} tx_t;
  logic rx_meta, rx_s;
  rx_t rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic rx_rdy, rx_rdy_n;
  pr_t pr_st, pr_st_n;
  logic [7:0] hold, hold_n;
  logic [15:0] cmd_q, cmd_n;
  logic rdy, rdy_n, accept;
  tx_t tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [3:0] tx_bit, tx_bit_n;
  logic [9:0] tx_sh, tx_sh_n;
  logic sent, sent_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s <= 1'b1;
      rx_st <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_rdy <= 1'b0;
      pr_st <= W_HI;
      hold <= '0;
      cmd_q <= '0;
      rdy <= 1'b0;
      tx_st <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '1;
      sent <= 1'b0;
    end else begin
      rx_meta <= bus.RX;
      rx_s <= rx_meta;
      rx_st <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh <= rx_sh_n;
      rx_rdy <= rx_rdy_n;
      pr_st <= pr_st_n;
      hold <= hold_n;
      cmd_q <= cmd_n;
      rdy <= rdy_n;
      tx_st <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh <= tx_sh_n;
      sent <= sent_n;
    end
  end
  always_comb begin
    rx_st_n = rx_st;
    rx_cnt_n = rx_cnt + 1'b1;
    rx_bit_n = rx_bit;
    rx_sh_n = rx_sh;
    rx_rdy_n = 1'b0;
    case (rx_st)
      R_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_s) rx_st_n = R_START;
      end
      R_START: if (rx_cnt == HALF) begin
        rx_cnt_n = '0;
        rx_st_n = rx_s ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt == FULL) begin
        rx_cnt_n = '0;
        rx_sh_n = {rx_s, rx_sh[7:1]};
        rx_bit_n = rx_bit + 1'b1;
        if (rx_bit == 3'd7) rx_st_n = R_STOP;
      end
      default: if (rx_cnt == FULL) begin
        rx_cnt_n = '0;
        rx_rdy_n = rx_s;
        rx_st_n = R_IDLE;
      end
    endcase
  end
  // bytes arriving while a command is still pending are dropped without advancing
  assign accept = rx_rdy && !rdy;
  always_comb begin
    pr_st_n = accept ? (pr_st == W_HI ? W_LO : W_HI) : pr_st;
    hold_n = (accept && pr_st == W_HI) ? rx_sh : hold;
    cmd_n = (accept && pr_st == W_LO) ? {hold, rx_sh} : cmd_q;
    rdy_n = (accept && pr_st == W_LO) || (rdy && !bus.clr_cmd_rdy);
  end
  // TX is tx_sh[0]; shifting in ones leaves the line idle-high after the stop bit
  always_comb begin
    tx_st_n = tx_st;
    tx_cnt_n = tx_cnt + 1'b1;
    tx_bit_n = tx_bit;
    tx_sh_n = tx_sh;
    sent_n = 1'b0;
    if (tx_st == T_IDLE) begin
      tx_cnt_n = '0;
      if (bus.send_resp && !sent) begin
        tx_st_n = T_XMIT;
        tx_sh_n = {1'b1, bus.resp, 1'b0};
        tx_bit_n = '0;
      end
    end else if (tx_cnt == FULL) begin
      tx_cnt_n = '0;
      tx_sh_n = {1'b1, tx_sh[9:1]};
      tx_bit_n = tx_bit + 1'b1;
      if (tx_bit == 4'd9) begin
        tx_st_n = T_IDLE;
        sent_n = 1'b1;
      end
    end
  end
  assign bus.TX = tx_sh[0];
  assign bus.cmd = cmd_q;
  assign bus.cmd_rdy = rdy;
  assign bus.resp_sent = sent;
  assign bus.tx_busy = (tx_st == T_XMIT);
endmodule
